mem_responder: RTL and testbench

Memory-side responder for the tagged instruction/data bus used by the I-cache and D-cache front ends.
- Accepts one BUS_LOAD or BUS_STORE per cycle and answers in the same cycle with a 4-bit response tag; 0 means rejected, initiator retries.
- Returns load data exactly MEM_LATENCY cycles after acceptance, marked with the matching tag.
- Serves as the synthesizable behavioural memory behind the cache/bank hierarchy.

---
 rtl/mem_responder_pkg.sv | 27 ++
 rtl/mem_responder_tag_alloc.sv | 53 +++++
 rtl/mem_responder.sv | 113 +++++++++++
 tb/tb_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared bus types and helpers for the tagged memory bus.
// Used by mem_responder and mem_tag_alloc.
package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef logic [3:0]  MEM_TAG_t;
    typedef logic [63:0] MEM_BLOCK_t;

    typedef struct packed {
        logic       valid;
        MEM_TAG_t   tag;
        MEM_BLOCK_t data;
    } mem_pipe_entry_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/mem_responder_tag_alloc.sv
// Tag free-list: lowest-free priority encoder with allocate/free ports.
// Tag t maps to free_vec[t-1]; tag 0 is never handed out.
module mem_tag_alloc
    import sys_defs::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     alloc_en,
    input  logic     free_en,
    input  MEM_TAG_t free_tag,
    output MEM_TAG_t alloc_tag,
    output logic     full
);

    logic [NUM_TAGS-1:0] free_vec;
    logic [NUM_TAGS-1:0] free_vec_next;

    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_tag = MEM_TAG_t'(i + 1);
            end
        end
    end

    assign full = ~|free_vec;

    // An allocated tag is always currently free and a freed tag is always
    // currently busy, so both updates can apply in the same cycle.
    always_comb begin
        free_vec_next = free_vec;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (alloc_en && (alloc_tag == MEM_TAG_t'(i + 1))) begin
                free_vec_next[i] = 1'b0;
            end
            if (free_en && (free_tag == MEM_TAG_t'(i + 1))) begin
                free_vec_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            free_vec <= '1;
        end else begin
            free_vec <= free_vec_next;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Behavioural tagged memory responder with fixed-latency load returns.
// Optional MEM_RANDOM_STALL_EN: LFSR-driven pseudo-random command rejection.
module mem_responder
    import sys_defs::*;
#(
    parameter int MEM_LATENCY = 10,
    parameter int NUM_TAGS    = 15,
    parameter int MEM_WORDS   = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [31:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output MEM_TAG_t    mem2proc_response,
    output MEM_BLOCK_t  mem2proc_data,
    output MEM_TAG_t    mem2proc_tag
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [28:0] WORDS_LIM = 29'(MEM_WORDS);

    MEM_BLOCK_t      mem [MEM_WORDS];
    mem_pipe_entry_t pipe [MEM_LATENCY];

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             is_load;
    logic             is_store;
    logic             stall;
    logic             cmd_valid;
    logic             accept;
    logic             alloc_en;
    MEM_TAG_t         alloc_tag;
    logic             tags_full;
    MEM_BLOCK_t       snapshot;
    mem_pipe_entry_t  pipe_out;

    assign word_idx = proc2mem_addr[3+IDX_W-1:3];
    assign in_range = proc2mem_addr[31:3] < WORDS_LIM;
    assign is_load  = proc2mem_command == BUS_LOAD;
    assign is_store = proc2mem_command == BUS_STORE;

`ifdef MEM_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign stall = lfsr[1:0] == 2'b00;
`else
    assign stall = 1'b0;
`endif

    // alloc_tag is already 0 when no tag is free, which covers the full case
    assign cmd_valid         = (is_load || is_store) && !stall && !reset;
    assign mem2proc_response = cmd_valid ? alloc_tag : '0;
    assign accept            = mem2proc_response != '0;
    assign alloc_en          = accept && is_load;

    assign pipe_out = pipe[MEM_LATENCY-1];

    mem_tag_alloc #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_alloc (
        .clock     (clock),
        .reset     (reset),
        .alloc_en  (alloc_en),
        .free_en   (pipe_out.valid),
        .free_tag  (pipe_out.tag),
        .alloc_tag (alloc_tag),
        .full      (tags_full)
    );

    assign snapshot = in_range ? mem[word_idx] : '0;

    // Backing store is intentionally not reset
    always_ff @(posedge clock) begin
        if (accept && is_store && in_range) begin
            mem[word_idx] <= proc2mem_data;
        end
    end

    // Idle stages carry all-zero entries so the output needs no valid gating
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (alloc_en) begin
                pipe[0] <= '{valid: 1'b1, tag: alloc_tag, data: snapshot};
            end else begin
                pipe[0] <= '0;
            end
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign mem2proc_tag  = reset ? '0 : pipe_out.tag;
    assign mem2proc_data = reset ? '0 : pipe_out.data;

    logic unused_ok;
    assign unused_ok = tags_full;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver predicts responses and queues
// expected completions; a negedge monitor pops and compares completions.
module tb_mem_responder;
    import sys_defs::*;

    localparam int LAT   = 20;
    localparam int NT    = 15;
    localparam int WORDS = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd   = 2'd0;
    logic [31:0] addr  = 32'd0;
    logic [63:0] wdata = 64'd0;
    MEM_TAG_t    resp;
    MEM_TAG_t    ctag;
    MEM_BLOCK_t  cdata;

    mem_responder #(
        .MEM_LATENCY (LAT),
        .NUM_TAGS    (NT),
        .MEM_WORDS   (WORDS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2mem_command  (cmd),
        .proc2mem_addr     (addr),
        .proc2mem_data     (wdata),
        .mem2proc_response (resp),
        .mem2proc_data     (cdata),
        .mem2proc_tag      (ctag)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [WORDS];
    logic [15:0] mlfsr = 16'h0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    endtask

    // Model: a tag is busy while its load sits in the expected-completion queue
    function automatic int lowest_free();
        for (int t = 1; t <= NT; t++) begin
            bit used = 1'b0;
            foreach (exp_q[k]) if (exp_q[k].tag == t) used = 1'b1;
            if (!used) return t;
        end
        return 0;
    endfunction

    task automatic step(input bit rst, input logic [1:0] c, input logic [31:0] a,
                        input logic [63:0] d, output int acc);
        int er;
        bit stall;
        bit inr;
        int idx;
        @(posedge clock);
        #1;
        reset = rst; cmd = c; addr = a; wdata = d;
        #1;
        stall = 1'b0;
`ifdef MEM_RANDOM_STALL_EN
        stall = (mlfsr[1:0] == 2'b00);
        mlfsr = rst ? 16'hACE1 : {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
`endif
        er = (rst || !(c == 2'd1 || c == 2'd2) || stall) ? 0 : lowest_free();
        check("response", 64'(resp), 64'(er));
        inr = (a >> 3) < WORDS;
        idx = inr ? int'(a >> 3) : 0;
        if (er != 0 && c == 2'd1) exp_q.push_back('{er, inr ? model_mem[idx] : 64'h0, cyc + LAT});
        if (er != 0 && c == 2'd2 && inr) model_mem[idx] = d;
        if (rst) exp_q.delete();
        acc = er;
    endtask

    task automatic drain();
        int acc;
        repeat (LAT + 3) step(1'b0, 2'd0, 32'h0, 64'h0, acc);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("cmpl_tag", 64'(ctag), 64'(exp_q[0].tag));
            check("cmpl_data", cdata, exp_q[0].data);
            void'(exp_q.pop_front());
        end else begin
            check("idle_tag", 64'(ctag), 64'h0);
            check("idle_data", cdata, 64'h0);
        end
    end

    initial begin
        int acc;
        logic [1:0]  rc;
        logic [31:0] ra;
        logic [63:0] rd;
        bit          retry;

        for (int i = 0; i < WORDS; i++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            model_mem[i] = v;
            dut.mem[i]   = v;
        end

        step(1'b1, 2'd1, 32'h0, 64'h0, acc);
        step(1'b1, 2'd2, 32'h8, 64'h1, acc);

        // store then load to the same word
        step(1'b0, 2'd2, 32'h100, 64'hDEAD_BEEF_0000_1111, acc);
        step(1'b0, 2'd1, 32'h100, 64'h0, acc);
        drain();

        for (int i = 0; i < 5; i++) step(1'b0, 2'd1, 32'(i * 8), 64'h0, acc);
        drain();

        // saturate the free list and watch the first tag come back
        for (int i = 0; i < 24; i++) step(1'b0, 2'd1, 32'($urandom_range(0, 63) * 8), 64'h0, acc);
        drain();

        step(1'b0, 2'd1, 32'h200, 64'h0, acc);
        step(1'b0, 2'd2, 32'h200, 64'h5, acc);
        drain();
        step(1'b0, 2'd1, 32'h200, 64'h0, acc);
        drain();

        // reset with a load in flight
        step(1'b0, 2'd1, 32'h40, 64'h0, acc);
        repeat (3) step(1'b0, 2'd0, 32'h0, 64'h0, acc);
        step(1'b1, 2'd1, 32'h48, 64'h0, acc);
        step(1'b0, 2'd1, 32'h48, 64'h0, acc);
        drain();

        // out-of-range: load reads zero, store must not alias word 0
        step(1'b0, 2'd1, 32'(WORDS * 8), 64'h0, acc);
        step(1'b0, 2'd2, 32'(WORDS * 8), 64'hFFFF_0000_FFFF_0000, acc);
        step(1'b0, 2'd1, 32'h0, 64'h0, acc);
        drain();

        retry = 1'b0;
        rc = 2'd0; ra = 32'h0; rd = 64'h0;
        for (int i = 0; i < 1000; i++) begin
            if (!retry) begin
                rc = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0)
                    ra = 32'((WORDS + $urandom_range(0, 7)) * 8 + $urandom_range(0, 7));
                else
                    ra = 32'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
                rd = {$urandom, $urandom};
            end
            step(1'b0, rc, ra, rd, acc);
            retry = (rc == 2'd1 || rc == 2'd2) && acc == 0;
        end
        drain();

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
